// File: rtl/izh_synapse_driver.sv
// rtl/izh_synapse_driver.sv - synaptic current driver for an Izhikevich integrator
// Scans the previous step's spikes, accumulates weights with saturation, decays and presents I.
module izh_synapse_driver #(
    parameter int WIDTH     = 20,
    parameter int FR_WIDTH  = 11,
    parameter int N         = 8,
    parameter int TAU_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     step_valid,
    output logic                     step_ready,
    input  logic [N-1:0]             spikes,
    input  logic                     w_we,
    input  logic [$clog2(N)-1:0]     w_addr,
    input  logic signed [WIDTH-1:0]  w_data,
    output logic signed [WIDTH-1:0]  i_out,
    output logic                     i_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic signed [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    if (N < 2 || N > 64 || FR_WIDTH >= WIDTH || TAU_SHIFT < 1 || TAU_SHIFT >= WIDTH) begin : g_bad_params
        $error("izh_synapse_driver: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DECAY
    } state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            idx_q, idx_d;
    logic [N-1:0]             spike_q, spike_d;
    logic signed [WIDTH-1:0]  acc_q, acc_d;
    logic signed [WIDTH-1:0]  iout_q, iout_d;
    logic                     ivalid_q, ivalid_d;
    logic                     overrun_q, overrun_d;
    logic signed [WIDTH-1:0]  w_q [N];

    logic signed [WIDTH-1:0]  w_rd;
    logic signed [WIDTH:0]    sum_ext;
    logic signed [WIDTH-1:0]  sum_sat;
    logic signed [WIDTH-1:0]  acc_decay;

    // Combinational read of the current register value: a same-edge write lands after this read.
    assign w_rd    = w_q[idx_q];
    assign sum_ext = {acc_q[WIDTH-1], acc_q} + {w_rd[WIDTH-1], w_rd};
    assign sum_sat = (sum_ext[WIDTH] != sum_ext[WIDTH-1]) ?
                     (sum_ext[WIDTH] ? ACC_MIN : ACC_MAX) : sum_ext[WIDTH-1:0];
    assign acc_decay = acc_q - (acc_q >>> TAU_SHIFT);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        spike_d   = spike_q;
        acc_d     = acc_q;
        iout_d    = iout_q;
        ivalid_d  = 1'b0;
        overrun_d = overrun_q | (step_valid & (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (step_valid) begin
                    spike_d = spikes;
                    idx_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (spike_q[idx_q]) begin
                    acc_d = sum_sat;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DECAY;
                end
            end
            S_DECAY: begin
                acc_d    = acc_decay;
                iout_d   = acc_decay;
                ivalid_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            spike_q   <= '0;
            acc_q     <= '0;
            iout_q    <= '0;
            ivalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            spike_q   <= spike_d;
            acc_q     <= acc_d;
            iout_q    <= iout_d;
            ivalid_q  <= ivalid_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                w_q[k] <= '0;
            end
        end else if (w_we && (int'(w_addr) < N)) begin
            w_q[w_addr] <= w_data;
        end
    end

    assign step_ready = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign i_out      = iout_q;
    assign i_valid    = ivalid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_izh_synapse_driver.sv
// tb/tb_izh_synapse_driver.sv - directed self-checking bench for izh_synapse_driver
module tb_izh_synapse_driver;

    logic               clk;
    logic               rst;
    logic               step_valid;
    logic               step_ready;
    logic [7:0]         spikes;
    logic               w_we;
    logic [2:0]         w_addr;
    logic signed [19:0] w_data;
    logic signed [19:0] i_out;
    logic               i_valid;
    logic               busy;
    logic               overrun;

    int tests;
    int fails;

    izh_synapse_driver #(
        .WIDTH(20), .FR_WIDTH(11), .N(8), .TAU_SHIFT(3)
    ) dut (
        .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(step_ready),
        .spikes(spikes), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .i_out(i_out), .i_valid(i_valid), .busy(busy), .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        rst = 1'b1;
        step_valid = 1'b0;
        w_we = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic write_w(input int addr, input int data);
        w_we   = 1'b1;
        w_addr = 3'(addr);
        w_data = 20'(data);
        @(posedge clk);
        #1;
        w_we = 1'b0;
    endtask

    task automatic start_step(input logic [7:0] s);
        step_valid = 1'b1;
        spikes     = s;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
    endtask

    // lat = number of edges since the accepting edge when i_valid is first seen; -1 on timeout
    task automatic wait_valid(input int start, output int lat);
        int cnt;
        cnt = start;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (i_valid) begin
                lat = cnt;
                break;
            end
        end
    endtask

    task automatic run_step(input logic [7:0] s, output int lat);
        start_step(s);
        wait_valid(0, lat);
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (int'(i_out) !== 0) begin fails++; $display("FAIL reset_i_out got %0d want 0", i_out); end
        tests++; if (i_valid !== 1'b0) begin fails++; $display("FAIL reset_i_valid got %b want 0", i_valid); end
        tests++; if (step_ready !== 1'b1) begin fails++; $display("FAIL reset_step_ready got %b want 1", step_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
        rst = 1'b1;
        step_valid = 1'b1;
        spikes = 8'hFF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_valid = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_wins_busy got %b want 0", busy); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rst_wins_overrun got %b want 0", overrun); end
    endtask

    task automatic test_single_spike();
        int lat;
        write_w(2, 20480);
        start_step(8'b0000_0100);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL scan_busy got %b want 1", busy); end
        tests++; if (int'(i_out) !== 0) begin fails++; $display("FAIL scan_i_out_held got %0d want 0", i_out); end
        wait_valid(0, lat);
        tests++; if (lat !== 9) begin fails++; $display("FAIL single_latency got %0d want 9", lat); end
        tests++; if (int'(i_out) !== 17920) begin fails++; $display("FAIL single_i_out got %0d want 17920", i_out); end
        @(posedge clk);
        #1;
        tests++; if (i_valid !== 1'b0) begin fails++; $display("FAIL single_pulse_width got %b want 0", i_valid); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_step(8'h00, lat);
        tests++; if (lat !== 9 || int'(i_out) !== 15680) begin fails++; $display("FAIL decay1 got lat %0d i_out %0d want 9 15680", lat, i_out); end
        tests++; if (step_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", step_ready); end
        run_step(8'h00, lat);
        tests++; if (lat !== 9 || int'(i_out) !== 13720) begin fails++; $display("FAIL decay2 got lat %0d i_out %0d want 9 13720", lat, i_out); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun got %b want 0", overrun); end
    endtask

    task automatic test_saturation();
        int lat;
        do_reset();
        for (int k = 0; k < 8; k++) write_w(k, 200000);
        run_step(8'hFF, lat);
        tests++; if (int'(i_out) !== 458752) begin fails++; $display("FAIL sat_pos got %0d want 458752", i_out); end
        do_reset();
        for (int k = 0; k < 8; k++) write_w(k, -200000);
        run_step(8'hFF, lat);
        tests++; if (int'(i_out) !== -458752) begin fails++; $display("FAIL sat_neg got %0d want -458752", i_out); end
    endtask

    task automatic test_small_decay();
        int lat;
        do_reset();
        write_w(0, -16384);
        run_step(8'h01, lat);
        tests++; if (int'(i_out) !== -14336) begin fails++; $display("FAIL neg_decay got %0d want -14336", i_out); end
        do_reset();
        write_w(0, -1);
        run_step(8'h01, lat);
        tests++; if (int'(i_out) !== 0) begin fails++; $display("FAIL minus_one_decay got %0d want 0", i_out); end
        do_reset();
        write_w(0, 5);
        run_step(8'h01, lat);
        tests++; if (int'(i_out) !== 5) begin fails++; $display("FAIL five_first got %0d want 5", i_out); end
        run_step(8'h00, lat);
        tests++; if (int'(i_out) !== 5) begin fails++; $display("FAIL five_hold got %0d want 5", i_out); end
    endtask

    task automatic test_write_during_scan();
        int lat;
        do_reset();
        write_w(0, 100);
        start_step(8'h01);
        w_we   = 1'b1;
        w_addr = 3'd0;
        w_data = 20'sd900;
        @(posedge clk);
        #1;
        w_we = 1'b0;
        wait_valid(1, lat);
        tests++; if (lat !== 9 || int'(i_out) !== 88) begin fails++; $display("FAIL rw_old_weight got lat %0d i_out %0d want 9 88", lat, i_out); end
        run_step(8'h01, lat);
        tests++; if (int'(i_out) !== 865) begin fails++; $display("FAIL rw_new_weight got %0d want 865", i_out); end
    endtask

    task automatic test_overrun();
        int lat;
        do_reset();
        write_w(1, 1000);
        start_step(8'h02);
        @(posedge clk);
        #1;
        step_valid = 1'b1;
        spikes = 8'hFF;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set got %b want 1", overrun); end
        wait_valid(2, lat);
        tests++; if (lat !== 9 || int'(i_out) !== 875) begin fails++; $display("FAIL overrun_result got lat %0d i_out %0d want 9 875", lat, i_out); end
        run_step(8'h00, lat);
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        int seen;
        do_reset();
        write_w(3, 4096);
        start_step(8'hFF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++; if (step_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL abort_idle got ready %b busy %b want 1 0", step_ready, busy); end
        tests++; if (int'(i_out) !== 0 || i_valid !== 1'b0) begin fails++; $display("FAIL abort_out got i_out %0d i_valid %b want 0 0", i_out, i_valid); end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (i_valid) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_valid got %0d pulses want 0", seen); end
        run_step(8'hFF, lat);
        tests++; if (lat !== 9 || int'(i_out) !== 0) begin fails++; $display("FAIL abort_weights_cleared got lat %0d i_out %0d want 9 0", lat, i_out); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        step_valid = 1'b0;
        spikes = '0;
        w_we = 1'b0;
        w_addr = '0;
        w_data = '0;
        test_reset();
        test_single_spike();
        test_back_to_back();
        test_saturation();
        test_small_decay();
        test_write_during_scan();
        test_overrun();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
